// File: rtl/uart_receive.sv
// UART 8N1 receiver.
// The line is double-synchronised, the start bit is confirmed at its midpoint, and every
// later bit is sampled one full bit period after the previous sample. The FSM returns to
// idle at mid-stop-bit, so a start bit that directly follows the stop bit is still caught.
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_wire_in,
    output logic [7:0] data_byte_out,
    output logic       new_data_out,
    output logic       framing_error_out,
    output logic       busy_out
);

    localparam int BAUD_BIT_PERIOD = (INPUT_CLOCK_FREQ + BAUD_RATE - 1) / BAUD_RATE;
    localparam int HALF_PERIOD     = BAUD_BIT_PERIOD / 2;
    localparam int CntW            = (BAUD_BIT_PERIOD > 1) ? $clog2(BAUD_BIT_PERIOD) : 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_BIT_PERIOD - 1);
    // Guard against a zero half period at degenerate parameter choices.
    localparam logic [CntW-1:0] HalfLast = CntW'((HALF_PERIOD > 0) ? HALF_PERIOD - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            new_q;
    logic            ferr_q;
    logic [1:0]      sync_q;
    logic            rx_s;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_wire_in};
        end
    end

    assign rx_s = sync_q[1];

    // Receive FSM with baud counter, bit index, shift register and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            new_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            new_q  <= 1'b0;
            ferr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // A line already back high at mid-start is a glitch.
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (rx_s) begin
                            data_q <= shift_q;
                            new_q  <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_byte_out     = data_q;
    assign new_data_out      = new_q;
    assign framing_error_out = ferr_q;
    assign busy_out          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: small-ratio instance for frame behaviour, a default
// instance for the real baud divider, and a 1 MHz / 9600 instance for baud tolerance.
module tb_uart_receive;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rx, rx_def, rx_fast;

    logic [7:0] data, data_def, data_fast;
    logic       nd, nd_def, nd_fast;
    logic       fe, fe_def, fe_fast;
    logic       busy, busy_def, busy_fast;

    uart_receive #(.INPUT_CLOCK_FREQ(100), .BAUD_RATE(10)) dut (
        .clk_in(clk), .rst_in(rst), .rx_wire_in(rx),
        .data_byte_out(data), .new_data_out(nd), .framing_error_out(fe), .busy_out(busy)
    );

    uart_receive dut_def (
        .clk_in(clk), .rst_in(rst), .rx_wire_in(rx_def),
        .data_byte_out(data_def), .new_data_out(nd_def), .framing_error_out(fe_def),
        .busy_out(busy_def)
    );

    uart_receive #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(9600)) dut_fast (
        .clk_in(clk), .rst_in(rst), .rx_wire_in(rx_fast),
        .data_byte_out(data_fast), .new_data_out(nd_fast), .framing_error_out(fe_fast),
        .busy_out(busy_fast)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = 0;

    // Monitor state for the main and tolerance instances.
    int nd_cnt, fe_cnt, both_cnt, busy_cyc, nd_cyc;
    int f_nd_cnt, f_fe_cnt;
    logic [7:0] f_last;
    logic [7:0] bytes_q[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (nd) begin
            nd_cnt = nd_cnt + 1;
            bytes_q.push_back(data);
            nd_cyc = cyc;
        end
        if (fe) fe_cnt = fe_cnt + 1;
        if (nd && fe) both_cnt = both_cnt + 1;
        if (busy) busy_cyc = busy_cyc + 1;
        if (nd_fast) begin
            f_nd_cnt = f_nd_cnt + 1;
            f_last = data_fast;
        end
        if (fe_fast) f_fe_cnt = f_fe_cnt + 1;
    end

    task automatic clear_mon();
        nd_cnt = 0; fe_cnt = 0; both_cnt = 0; busy_cyc = 0; nd_cyc = 0;
        f_nd_cnt = 0; f_fe_cnt = 0; f_last = 8'h00;
        bytes_q.delete();
    endtask

    // Step n rising edges, then settle 1 time unit past the edge.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0: rx = v;
            1: rx_def = v;
            default: rx_fast = v;
        endcase
    endtask

    // Called at edge+1; each level lasts exactly clks cycles; line left high afterwards.
    task automatic drive_frame(input int which, input logic [7:0] d, input logic stop,
                               input int clks);
        set_line(which, 1'b0);
        if (which == 0) fall_cyc = cyc;
        hold(clks);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            hold(clks);
        end
        set_line(which, stop);
        hold(clks);
        set_line(which, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_def = 1'b1; rx_fast = 1'b1;
        clear_mon();
        hold(3);
        checks++; if (data !== 8'h00) begin errors++;
            $display("FAIL reset_data: got %h want 00", data); end
        checks++; if (nd !== 1'b0) begin errors++;
            $display("FAIL reset_new: got %b want 0", nd); end
        checks++; if (fe !== 1'b0) begin errors++;
            $display("FAIL reset_ferr: got %b want 0", fe); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        hold(5);
    endtask

    task automatic test_frame_a5();
        clear_mon();
        drive_frame(0, 8'hA5, 1'b1, 10);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL a5_busy_after_stop: got %b want 0", busy); end
        hold(20);
        checks++; if (nd_cnt != 1) begin errors++;
            $display("FAIL a5_pulses: got %0d want 1", nd_cnt); end
        checks++; if (data !== 8'hA5) begin errors++;
            $display("FAIL a5_data: got %h want a5", data); end
        checks++; if (bytes_q.size() < 1 || bytes_q[0] !== 8'hA5) begin errors++;
            $display("FAIL a5_pulse_data: pulses %0d want byte a5", bytes_q.size()); end
        checks++; if (fe_cnt != 0) begin errors++;
            $display("FAIL a5_ferr: got %0d want 0", fe_cnt); end
        checks++; if (busy_cyc != 95) begin errors++;
            $display("FAIL a5_busy_cycles: got %0d want 95", busy_cyc); end
        checks++; if (nd_cyc - fall_cyc < 98 || nd_cyc - fall_cyc > 100) begin errors++;
            $display("FAIL a5_latency: got %0d want 98..100", nd_cyc - fall_cyc); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        hold(3);
        rx = 1'b1;
        hold(20);
        checks++; if (busy_cyc != 5) begin errors++;
            $display("FAIL glitch_busy_cycles: got %0d want 5", busy_cyc); end
        checks++; if (nd_cnt != 0 || fe_cnt != 0) begin errors++;
            $display("FAIL glitch_pulses: got new=%0d ferr=%0d want 0 0", nd_cnt, fe_cnt); end
        checks++; if (data !== 8'hA5) begin errors++;
            $display("FAIL glitch_data: got %h want a5", data); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL glitch_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_framing_error();
        clear_mon();
        drive_frame(0, 8'h3C, 1'b0, 10);
        hold(30);
        checks++; if (fe_cnt != 1) begin errors++;
            $display("FAIL ferr_pulses: got %0d want 1", fe_cnt); end
        checks++; if (nd_cnt != 0) begin errors++;
            $display("FAIL ferr_new: got %0d want 0", nd_cnt); end
        checks++; if (data !== 8'hA5) begin errors++;
            $display("FAIL ferr_data: got %h want a5", data); end
        checks++; if (both_cnt != 0) begin errors++;
            $display("FAIL ferr_both: got %0d want 0", both_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        drive_frame(0, 8'h00, 1'b1, 10);
        drive_frame(0, 8'hFF, 1'b1, 10);
        hold(20);
        checks++; if (nd_cnt != 2) begin errors++;
            $display("FAIL b2b_pulses: got %0d want 2", nd_cnt); end
        checks++; if (bytes_q.size() < 2 || bytes_q[0] !== 8'h00 || bytes_q[1] !== 8'hFF)
        begin errors++;
            $display("FAIL b2b_bytes: got %0d pulses want 00 then ff", bytes_q.size()); end
        checks++; if (fe_cnt != 0) begin errors++;
            $display("FAIL b2b_ferr: got %0d want 0", fe_cnt); end
        checks++; if (data !== 8'hFF) begin errors++;
            $display("FAIL b2b_data: got %h want ff", data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h5A;
        clear_mon();
        rx = 1'b0;
        hold(10);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            hold(10);
        end
        rx = d[4];
        hold(5);
        #3 rst = 1'b1;
        #1;
        checks++; if (data !== 8'h00) begin errors++;
            $display("FAIL rstmid_data: got %h want 00", data); end
        checks++; if (busy !== 1'b0 || nd !== 1'b0 || fe !== 1'b0) begin errors++;
            $display("FAIL rstmid_flags: got busy=%b new=%b ferr=%b want 0 0 0", busy, nd, fe);
        end
        rx = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(20);
        checks++; if (nd_cnt != 0 || fe_cnt != 0) begin errors++;
            $display("FAIL rstmid_pulses: got new=%0d ferr=%0d want 0 0", nd_cnt, fe_cnt); end
        drive_frame(0, 8'h5A, 1'b1, 10);
        hold(20);
        checks++; if (nd_cnt != 1 || data !== 8'h5A) begin errors++;
            $display("FAIL rstmid_refill: got %0d pulses data %h want 1 5a", nd_cnt, data); end
    endtask

    // Default divider: 10417 clocks per bit, so a false start is held for 5208 cycles.
    task automatic test_default_params();
        int n;
        int bad;
        n = 0;
        bad = 0;
        rx_def = 1'b0;
        hold(3);
        rx_def = 1'b1;
        repeat (6000) begin
            @(negedge clk);
            if (busy_def) n++;
            if (nd_def || fe_def) bad++;
        end
        hold(1);
        checks++; if (n != 5208) begin errors++;
            $display("FAIL def_half_period: got %0d want 5208", n); end
        checks++; if (bad != 0 || data_def !== 8'h00) begin errors++;
            $display("FAIL def_no_output: got %0d pulses data %h want 0 00", bad, data_def);
        end
    endtask

    // 1 MHz / 9600 gives 105 clocks per bit; drive 102 (fast) and 106 (slow).
    task automatic test_baud_tolerance();
        clear_mon();
        drive_frame(2, 8'h81, 1'b1, 102);
        hold(50);
        checks++; if (f_nd_cnt != 1 || f_last !== 8'h81) begin errors++;
            $display("FAIL tol_fast: got %0d pulses byte %h want 1 81", f_nd_cnt, f_last); end
        clear_mon();
        drive_frame(2, 8'h81, 1'b1, 106);
        hold(50);
        checks++; if (f_nd_cnt != 1 || f_last !== 8'h81) begin errors++;
            $display("FAIL tol_slow: got %0d pulses byte %h want 1 81", f_nd_cnt, f_last); end
        checks++; if (f_fe_cnt != 0) begin errors++;
            $display("FAIL tol_ferr: got %0d want 0", f_fe_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_params();
        test_baud_tolerance();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 The module SHALL have parameter INPUT_CLOCK_FREQ, default 100_000_000, which is the clk_in frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, which is the serial bit rate in bits/s.
REQ-003 The module SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port rx_wire_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The module SHALL have port data_byte_out, output, 8 bits: the last correctly framed byte received.
REQ-007 The module SHALL have port new_data_out, output, 1 bit: a one-cycle pulse when data_byte_out is updated.
REQ-008 The module SHALL have port framing_error_out, output, 1 bit: a one-cycle pulse when a frame's stop bit is sampled low.
REQ-009 The module SHALL have port busy_out, output, 1 bit: high while a frame is being received.

Function
REQ-010 The module SHALL compute BAUD_BIT_PERIOD = (INPUT_CLOCK_FREQ + BAUD_RATE - 1) / BAUD_RATE clocks, rounded up.
REQ-011 The module SHALL compute HALF_PERIOD = BAUD_BIT_PERIOD / 2, rounded down.
REQ-012 The baud counter width SHALL be $clog2(BAUD_BIT_PERIOD), and the counter SHALL never exceed BAUD_BIT_PERIOD-1.
REQ-013 rx_wire_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; the synchronizer output (rx_s) is the only line used internally.
REQ-014 The frame format SHALL be 8N1: start bit low, 8 data bits LSB first, one stop bit high, no parity.
REQ-015 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-016 IDLE: when rx_s==0, the FSM SHALL go to START with the counter cleared; otherwise it SHALL remain in IDLE.
REQ-017 START: the counter SHALL increment to HALF_PERIOD-1, and rx_s SHALL be sampled in that cycle.
REQ-018 START sample: if rx_s==0, the FSM SHALL go to DATA with counter=0 and bit index=0; if rx_s==1 (glitch), it SHALL return to IDLE with no output pulse.
REQ-019 DATA: the counter SHALL run to BAUD_BIT_PERIOD-1; in that cycle rx_s SHALL be shifted into the MSB of an 8-bit shift register (shift right), and the bit index SHALL increment.
REQ-020 DATA: after the 8th data sample, the FSM SHALL go to STOP with counter=0.
REQ-021 STOP: the counter SHALL run to BAUD_BIT_PERIOD-1 and sample rx_s, which falls at mid-stop-bit; the FSM SHALL then go to IDLE regardless of the sampled value.
REQ-022 STOP sample high: the next cycle SHALL show data_byte_out = shift register, new_data_out=1 for exactly one cycle, and framing_error_out=0.
REQ-023 STOP sample low: the next cycle SHALL show framing_error_out=1 for exactly one cycle, new_data_out=0, and data_byte_out unchanged.
REQ-024 new_data_out and framing_error_out SHALL never be high in the same cycle, and each SHALL be 0 in every cycle other than those of REQ-022/023.
REQ-025 busy_out SHALL be 1 exactly when the state is START, DATA, or STOP.
REQ-026 Because the FSM returns to IDLE at mid-stop, it SHALL detect a start bit that immediately follows the stop bit with no extra idle time.
REQ-027 Latency: the new_data_out pulse SHALL occur 2 (synchronizer) + 1 + (HALF_PERIOD) + 9·BAUD_BIT_PERIOD + 1 cycles (±1) after the line's start-bit falling edge.
REQ-028 data_byte_out SHALL hold its value until the next good frame; there is no consumer handshake, and a byte not taken by the consumer is overwritten silently.
REQ-029 A low line at reset release SHALL be treated as a start bit once it appears on rx_s.

Reset
REQ-030 While rst_in=1 (asynchronously): state=IDLE, counter=0, bit index=0, shift register=0x00, synchronizer flops=1.
REQ-031 While rst_in=1 (asynchronously): data_byte_out=0x00, new_data_out=0, framing_error_out=0, busy_out=0.
REQ-032 Reset mid-frame SHALL discard the partial byte with no output pulse.

Verification
(INPUT_CLOCK_FREQ=100, BAUD_RATE=10 → BAUD_BIT_PERIOD=10, HALF_PERIOD=5; line driven 10 clocks/bit)
REQ-033 The bench SHALL cover: frame 0xA5 with stop high -> data_byte_out=0xA5, one new_data_out pulse, framing_error_out stays 0, busy_out falls after mid-stop.
REQ-034 The bench SHALL cover: line low for 3 clocks then high -> busy_out pulses, FSM returns to IDLE, no new_data_out and no framing_error_out, data_byte_out unchanged.
REQ-035 The bench SHALL cover: after 0xA5, frame 0x3C with stop bit low -> one framing_error_out pulse, data_byte_out stays 0xA5.
REQ-036 The bench SHALL cover: back-to-back 0x00 then 0xFF with no idle gap -> two new_data_out pulses, carrying 0x00 then 0xFF.
REQ-037 The bench SHALL cover: rst_in asserted during data bit 4 of 0x5A, asynchronous to clk_in -> all outputs 0 immediately, no pulse; a following full 0x5A frame is received correctly.
REQ-038 The bench SHALL cover: default parameters (100 MHz / 9600) -> BAUD_BIT_PERIOD=10417, and frame 0x81 is received correctly at 9600 baud ±2%.
